// File: rtl/video_pkg.sv
// Shared TMDS types, control tokens and the stage-A transition-minimising helper.
package video_pkg;

  typedef logic [9:0]        tmds_sym_t;
  typedef logic signed [4:0] disparity_t;

  localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

  // Control token selected by {v_sync, h_sync}.
  function automatic tmds_sym_t ctrl_token(input logic [1:0] vh);
    case (vh)
      2'b01:   return TMDS_CTRL_01;
      2'b10:   return TMDS_CTRL_10;
      2'b11:   return TMDS_CTRL_11;
      default: return TMDS_CTRL_00;
    endcase
  endfunction

  // Population count of a byte (0..8).
  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // Stage A: XOR/XNOR chain chosen to minimise transitions; bit 8 flags XOR.
  function automatic logic [8:0] stage_a(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/hdmi_tmds_formatter_encoder.sv
// One TMDS channel: stage A (transition minimising) and stage B (DC balancing)
// with its own running disparity; de/ctrl travel alongside q_m so the
// control and data paths stay delay-matched.
module tmds_channel_encoder
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic       de,
  output tmds_sym_t  sym
);

  logic [8:0]       q_m_q;
  logic             de_q;
  logic [1:0]       ctrl_q;
  disparity_t       cnt_q, cnt_d;
  tmds_sym_t        sym_q, sym_d;
  logic [3:0]       n1, n0;
  logic             q8;
  logic signed [5:0] cnt_ext, diff, cnt_ext_d;

  // Stage A register: q_m plus the matching de/ctrl sample.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is sampled only on the clock edge.
    if (rst) begin
      q_m_q  <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      q_m_q  <= stage_a(data);
      de_q   <= de;
      ctrl_q <= ctrl;
    end
  end

  // Stage B: choose inversion from running disparity, or emit a control token.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    sym_d     = ctrl_token(ctrl_q);
    cnt_ext_d = '0;
    n1        = ones8(q_m_q[7:0]);
    n0        = 4'd8 - n1;
    q8        = q_m_q[8];
    cnt_ext   = {cnt_q[4], cnt_q};
    diff      = $signed({2'b00, n1}) - $signed({2'b00, n0});
    if (de_q) begin
      if ((cnt_q == 5'sd0) || (n1 == n0)) begin
        sym_d     = {~q8, q8, (q8 ? q_m_q[7:0] : ~q_m_q[7:0])};
        cnt_ext_d = q8 ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if (((cnt_q > 5'sd0) && (n1 > n0)) || ((cnt_q < 5'sd0) && (n0 > n1))) begin
        sym_d     = {1'b1, q8, ~q_m_q[7:0]};
        cnt_ext_d = cnt_ext - diff + (q8 ? 6'sd2 : 6'sd0);
      end else begin
        sym_d     = {1'b0, q8, q_m_q[7:0]};
        cnt_ext_d = cnt_ext + diff - (q8 ? 6'sd0 : 6'sd2);
      end
    end
    cnt_d = cnt_ext_d[4:0];
  end

  // Stage B register: symbol and disparity; control periods clear cnt via cnt_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q <= TMDS_CTRL_00;
      cnt_q <= '0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  // Disparity is bounded to +/-8 by construction; anything else is a wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((cnt_ext_d >= -6'sd8) && (cnt_ext_d <= 6'sd8));
    end
  end

  assign sym = sym_q;

endmodule

// File: rtl/hdmi_tmds_formatter.sv
// Video stream to three TMDS symbols per pixel clock: optional input register,
// sync polarity, three channel encoders and the pipeline-filled flag.
module hdmi_tmds_formatter
  import video_pkg::*;
#(
  parameter bit SYNC_INVERT = 1'b0,
  parameter bit INPUT_REG   = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        active_draw_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic        symbols_valid
);

  localparam int LAT = 2 + int'(INPUT_REG);

  logic [23:0] enc_pix;
  logic        enc_de;
  logic [1:0]  enc_vh;
  logic [1:0]  vh_pol;
  logic [LAT-1:0] vld_q;

  assign vh_pol = {v_sync_in, h_sync_in} ^ {2{SYNC_INVERT}};

  if (INPUT_REG) begin : g_in_reg
    logic [23:0] pix_q;
    logic        de_q;
    logic [1:0]  vh_q;

    // Input register: one sample of every input before encoding.
    always_ff @(posedge clk_pixel) begin
      if (rst) begin
        pix_q <= '0;
        de_q  <= 1'b0;
        vh_q  <= 2'b00;
      end else begin
        pix_q <= pixel_in;
        de_q  <= active_draw_in;
        vh_q  <= vh_pol;
      end
    end

    assign enc_pix = pix_q;
    assign enc_de  = de_q;
    assign enc_vh  = vh_q;
  end else begin : g_in_direct
    assign enc_pix = pixel_in;
    assign enc_de  = active_draw_in;
    assign enc_vh  = vh_pol;
  end

  tmds_channel_encoder u_enc_b (
    .clk  (clk_pixel),
    .rst  (rst),
    .data (enc_pix[7:0]),
    .ctrl (enc_vh),
    .de   (enc_de),
    .sym  (tmds_ch0)
  );

  tmds_channel_encoder u_enc_g (
    .clk  (clk_pixel),
    .rst  (rst),
    .data (enc_pix[15:8]),
    .ctrl (2'b00),
    .de   (enc_de),
    .sym  (tmds_ch1)
  );

  tmds_channel_encoder u_enc_r (
    .clk  (clk_pixel),
    .rst  (rst),
    .data (enc_pix[23:16]),
    .ctrl (2'b00),
    .de   (enc_de),
    .sym  (tmds_ch2)
  );

  // Fill marker: a 1 shifts through LAT stages after reset releases.
  always_ff @(posedge clk_pixel) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[LAT-2:0], 1'b1};
  end

  assign symbols_valid = vld_q[LAT-1];

endmodule

// File: tb/tb_hdmi_tmds_formatter.sv
// Self-checking bench: normal-polarity registered-input DUT plus an
// inverted-sync direct-input DUT, both compared to a behavioural TMDS model.
module tb_hdmi_tmds_formatter;

  localparam int LAT_A     = 3;
  localparam int LAT_B     = 2;
  localparam int MAX_STEPS = 12000;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pixel_in = '0;
  logic        active_draw_in = 1'b0;
  logic        h_sync_in = 1'b0;
  logic        v_sync_in = 1'b0;
  logic [9:0]  a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;
  logic        a_valid, b_valid;

  logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] SEQ0 [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};

  bit          rst_h [MAX_STEPS];
  bit          de_h  [MAX_STEPS];
  logic [1:0]  vh_h  [MAX_STEPS];
  logic [23:0] pix_h [MAX_STEPS];
  logic [9:0]  obs_a0 [MAX_STEPS];
  logic [9:0]  obs_b0 [MAX_STEPS];
  logic        obs_av [MAX_STEPS];
  logic        obs_bv [MAX_STEPS];

  int s = 0;
  int n_checks = 0;
  int n_errors = 0;
  int disp [2][3];
  int line_sum [3];

  always #5 clk_pixel = ~clk_pixel;

  hdmi_tmds_formatter #(.SYNC_INVERT(1'b0), .INPUT_REG(1'b1)) dut_a (
    .clk_pixel(clk_pixel), .rst(rst), .pixel_in(pixel_in),
    .active_draw_in(active_draw_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .tmds_ch0(a_ch0), .tmds_ch1(a_ch1), .tmds_ch2(a_ch2), .symbols_valid(a_valid)
  );

  hdmi_tmds_formatter #(.SYNC_INVERT(1'b1), .INPUT_REG(1'b0)) dut_b (
    .clk_pixel(clk_pixel), .rst(rst), .pixel_in(pixel_in),
    .active_draw_in(active_draw_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .tmds_ch0(b_ch0), .tmds_ch1(b_ch1), .tmds_ch2(b_ch2), .symbols_valid(b_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, s, obs, exp);
    end
  endtask

  function automatic int ones10(input logic [9:0] v);
    return $countones(v);
  endfunction

  // Reference TMDS encoder written from the encoding rules; disparity passed in.
  function automatic logic [9:0] ref_encode(input logic [7:0] d, input int cnt);
    int         n1, nq1, nq0;
    bit         xn, q8;
    logic [7:0] qm;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8  = !xn;
    nq1 = $countones(qm);
    nq0 = 8 - nq1;
    if (cnt == 0 || nq1 == nq0) return {~q8, q8, (q8 ? qm : ~qm)};
    if ((cnt > 0 && nq1 > nq0) || (cnt < 0 && nq0 > nq1)) return {1'b1, q8, ~qm};
    return {1'b0, q8, qm};
  endfunction

  // Receiver-side decode back to the original byte.
  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Compare one DUT's current outputs to the model entry LAT-1 steps back.
  task automatic check_model(input int k);
    int         lat, j;
    bit         killed;
    logic [9:0] obs [3];
    logic       obs_v;
    logic [9:0] e;
    logic [7:0] byte_v;
    logic [1:0] vh;
    string      pfx;
    lat = (k == 1) ? LAT_B : LAT_A;
    pfx = (k == 1) ? "inv" : "nrm";
    if (k == 1) begin
      obs[0] = b_ch0; obs[1] = b_ch1; obs[2] = b_ch2; obs_v = b_valid;
    end else begin
      obs[0] = a_ch0; obs[1] = a_ch1; obs[2] = a_ch2; obs_v = a_valid;
    end
    j = s - lat + 1;
    killed = (j < 0);
    for (int t = (j < 0 ? 0 : j); t <= s; t++) if (rst_h[t]) killed = 1'b1;
    if (killed) begin
      check({pfx, "_valid_off"}, 32'(obs_v), 32'd0);
      for (int c = 0; c < 3; c++) begin
        disp[k][c] = 0;
        if (k == 0) line_sum[c] = 0;
        check($sformatf("%s_rst_ch%0d", pfx, c), 32'(obs[c]), 32'(TOK[0]));
      end
    end else begin
      check({pfx, "_valid_on"}, 32'(obs_v), 32'd1);
      if (de_h[j]) begin
        for (int c = 0; c < 3; c++) begin
          byte_v = pix_h[j][8*c +: 8];
          e = ref_encode(byte_v, disp[k][c]);
          disp[k][c] += 2 * ones10(e) - 10;
          check($sformatf("%s_data_ch%0d", pfx, c), 32'(obs[c]), 32'(e));
          if (k == 0) begin
            check($sformatf("decode_ch%0d", c), 32'(decode(obs[c])), 32'(byte_v));
            line_sum[c] += ones10(obs[c]) - 5;
            check($sformatf("disp_bound_ch%0d", c),
                  32'(line_sum[c] >= -8 && line_sum[c] <= 8), 32'd1);
          end
        end
      end else begin
        vh = (k == 1) ? ~vh_h[j] : vh_h[j];
        for (int c = 0; c < 3; c++) begin
          disp[k][c] = 0;
          if (k == 0) line_sum[c] = 0;
        end
        check({pfx, "_tok_ch0"}, 32'(obs[0]), 32'(TOK[vh]));
        check({pfx, "_tok_ch1"}, 32'(obs[1]), 32'(TOK[0]));
        check({pfx, "_tok_ch2"}, 32'(obs[2]), 32'(TOK[0]));
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, sample on the falling edge and check.
  task automatic drive(input bit r, input bit de, input bit hh, input bit vv, input logic [23:0] p);
    if (s >= MAX_STEPS) begin
      $display("FAIL step_budget exceeded at step=%0d", s);
      $fatal(1, "step budget exceeded");
    end
    rst = r; active_draw_in = de; h_sync_in = hh; v_sync_in = vv; pixel_in = p;
    rst_h[s] = r; de_h[s] = de; vh_h[s] = {vv, hh}; pix_h[s] = p;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    obs_a0[s] = a_ch0; obs_b0[s] = b_ch0; obs_av[s] = a_valid; obs_bv[s] = b_valid;
    check_model(0);
    check_model(1);
    s++;
  endtask

  function automatic logic [23:0] rand_pix();
    int mode;
    mode = $urandom_range(0, 7);
    if (mode == 0) return 24'h000000;
    if (mode == 1) return 24'hFFFFFF;
    return 24'($urandom);
  endfunction

  // First step at or after 'from' where valid is high, as an edge count from 'from'.
  function automatic int fill_edges(input int from, input bit which_b);
    for (int t = from; t < from + 10 && t < s; t++) begin
      if ((which_b ? obs_bv[t] : obs_av[t]) === 1'b1) return t - from + 1;
    end
    return -1;
  endfunction

  initial begin
    int rel, a, t3, d, e, p;
    logic [1:0] vhv;

    // Reset, then idle with syncs low.
    @(negedge clk_pixel);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 24'($urandom));
    rel = s;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 24'($urandom));
    check("reset_ch0", 32'(obs_a0[rel - 1]), 32'(TOK[0]));
    check("reset_valid", 32'(obs_av[rel - 1]), 32'd0);
    check("fill_latency_nrm", 32'(fill_edges(rel, 1'b0)), 32'(LAT_A));
    check("fill_latency_inv", 32'(fill_edges(rel, 1'b1)), 32'(LAT_B));

    // Control tokens for each sync combination.
    for (int k = 1; k < 4; k++) begin
      vhv = 2'(k);
      a = s;
      for (int i = 0; i < 4; i++) drive(0, 0, vhv[0], vhv[1], 24'($urandom));
      check($sformatf("token_nrm_%0d", k), 32'(obs_a0[a + LAT_A - 1]), 32'(TOK[vhv]));
      check($sformatf("token_inv_%0d", k), 32'(obs_b0[a + LAT_B - 1]), 32'(TOK[~vhv]));
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 24'($urandom));

    // Blue = 0x00 for four pixels from zero disparity.
    t3 = s;
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, {16'($urandom), 8'h00});
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 24'($urandom));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq0_nrm_%0d", i), 32'(obs_a0[t3 + LAT_A - 1 + i]), 32'(SEQ0[i]));
      check($sformatf("seq0_inv_%0d", i), 32'(obs_b0[t3 + LAT_B - 1 + i]), 32'(SEQ0[i]));
    end

    // Random active lines separated by random control periods.
    for (int ln = 0; ln < 50; ln++) begin
      for (int i = 0; i < 200; i++) drive(0, 1, 1'($urandom), 1'($urandom), rand_pix());
      for (int i = 0; i < 6; i++) drive(0, 0, 1'($urandom), 1'($urandom), 24'($urandom));
    end

    // Line boundary: token lands exactly LAT later; next data restarts at cnt=0.
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 0, rand_pix());
    d = s;
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 24'($urandom));
    p = s;
    drive(0, 1, 0, 0, {16'($urandom), 8'h00});
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 24'($urandom));
    check("boundary_token", 32'(obs_a0[d + LAT_A - 1]), 32'(TOK[1]));
    check("boundary_last_data", 32'(obs_a0[d + LAT_A - 2] != TOK[1]), 32'd1);
    check("restart_cnt0", 32'(obs_a0[p + LAT_A - 1]), 32'h100);

    // One-cycle reset in mid-line.
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, rand_pix());
    e = s;
    drive(1, 1, 0, 0, rand_pix());
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, rand_pix());
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 24'($urandom));
    check("midrst_ch0", 32'(obs_a0[e]), 32'(TOK[0]));
    check("midrst_valid", 32'(obs_av[e]), 32'd0);
    check("midrst_refill_nrm", 32'(fill_edges(e + 1, 1'b0)), 32'(LAT_A));
    check("midrst_refill_inv", 32'(fill_edges(e + 1, 1'b1)), 32'(LAT_B));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
